// File: rtl/icache_fill_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl_if
//   Bundles the three buses of the I-cache fill controller:
//   - core side:   req_valid/req_addr/req_ready, rsp_valid/rsp_data/rsp_err
//   - store side:  st_* compare-read / fill-write access and its hit/valid/data
//   - memory side: mem_req/mem_addr/mem_gnt, mem_rsp_valid/mem_rsp_data
//   master: the controller.  slave: the environment (core, store, memory).
// ---------------------------------------------------------------------------
interface icache_fill_ctrl_if #(
    parameter int TAG_W    = 22,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 6,
    parameter int DATA_W   = 64
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

    // core
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_ready;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    // store
    logic                st_enable;
    logic [TAG_W-1:0]    st_tag;
    logic [INDEX_W-1:0]  st_index;
    logic [OFFSET_W-1:0] st_offset;
    logic [DATA_W-1:0]   st_data_in;
    logic                st_comp;
    logic                st_write;
    logic                st_valid_in;
    logic                st_hit;
    logic                st_valid;
    logic [DATA_W-1:0]   st_data_out;
    // lower memory level
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_gnt;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;

    modport master (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output st_enable, st_tag, st_index, st_offset, st_data_in,
               st_comp, st_write, st_valid_in,
        input  st_hit, st_valid, st_data_out,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  st_enable, st_tag, st_index, st_offset, st_data_in,
               st_comp, st_write, st_valid_in,
        output st_hit, st_valid, st_data_out,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//   Initiator-side controller for the L1 instruction cache store. A fetch is
//   looked up with a compare-read; on a miss the 64B line is requested from
//   the lower level, written into the store word by word, and the lookup is
//   repeated so the response always comes out of the store.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : icache_fill_ctrl_if.master (core, store and memory buses)
//   hit_cnt   : saturating count of hit responses
//   miss_cnt  : saturating count of line fills started
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
    parameter int TAG_W    = 22,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 6,
    parameter int DATA_W   = 64,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    icache_fill_ctrl_if.master bus,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int WSEL_W = OFFSET_W - 3;   // word select within a line (8B words)

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_FILL,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [WSEL_W-1:0]   r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic                w_latch;
    logic                w_rsp_valid;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_rsp_err;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_cnt_clr;
    logic                w_cnt_inc;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;

    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_index  = r_addr[OFFSET_W +: INDEX_W];
    assign w_offset = r_addr[OFFSET_W-1:0];

    // Next state plus every combinational output. Store and memory buses
    // carry address fields only while they are actually in use, so idle
    // cycles show all-zero buses.
    always_comb begin
        w_next          = r_state;
        w_latch         = 1'b0;
        w_rsp_valid     = 1'b0;
        w_rsp_data      = '0;
        w_rsp_err       = 1'b0;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;
        bus.req_ready   = 1'b0;
        bus.st_enable   = 1'b0;
        bus.st_tag      = '0;
        bus.st_index    = '0;
        bus.st_offset   = '0;
        bus.st_data_in  = '0;
        bus.st_comp     = 1'b0;
        bus.st_write    = 1'b0;
        bus.st_valid_in = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_addr    = '0;

        unique case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_latch = 1'b1;
                    // fetches must be 8B aligned; anything else is answered
                    // with an error and never touches the store
                    w_next  = (bus.req_addr[2:0] != 3'b000) ? S_ERR : S_LOOKUP;
                end
            end

            S_ERR: begin
                w_rsp_valid = 1'b1;
                w_rsp_err   = 1'b1;
                w_next      = S_IDLE;
            end

            S_LOOKUP: begin
                bus.st_enable = 1'b1;
                bus.st_comp   = 1'b1;
                bus.st_tag    = w_tag;
                bus.st_index  = w_index;
                bus.st_offset = w_offset;
                if (bus.st_hit && bus.st_valid) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = bus.st_data_out;
                    w_hit_inc   = 1'b1;
                    w_next      = S_IDLE;
                end else begin
                    w_miss_inc  = 1'b1;
                    w_next      = S_MREQ;
                end
            end

            S_MREQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {w_tag, w_index, {OFFSET_W{1'b0}}};
                if (bus.mem_gnt) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_FILL;
                end
            end

            S_FILL: begin
                // fill words arrive in order, so the beat counter alone picks
                // the destination word; idle beats leave the store untouched
                if (bus.mem_rsp_valid) begin
                    bus.st_enable   = 1'b1;
                    bus.st_write    = 1'b1;
                    bus.st_valid_in = 1'b1;
                    bus.st_tag      = w_tag;
                    bus.st_index    = w_index;
                    bus.st_offset   = {r_cnt, 3'b000};
                    bus.st_data_in  = bus.mem_rsp_data;
                    w_cnt_inc       = 1'b1;
                    if (r_cnt == '1) begin
                        w_next = S_LOOKUP;
                    end
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_latch) begin
                r_addr <= bus.req_addr;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;   // wraps to 0 after the last word
            end
        end
    end

    // Response is a registered one-cycle strobe; data and err are zero
    // whenever valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_ctrl
//   Bench for icache_fill_ctrl. The environment provides a cache store model
//   and a lower-memory responder; expected results come from a line-presence
//   model of the cache plus the fetch rules (misaligned -> error, present ->
//   hit, absent -> fill then hit) and a fixed memory content function.
// ---------------------------------------------------------------------------
module tb_icache_fill_ctrl;
    localparam int TAG_W    = 22;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 6;
    localparam int DATA_W   = 64;
    localparam int CNT_W    = 8;   // small so saturation is reachable quickly
    localparam int AW       = TAG_W + INDEX_W + OFFSET_W;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    icache_fill_ctrl_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) bus ();

    icache_fill_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory content: every 8B word is a function of its own address
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {1'b0, a[AW-1:3], 1'b1, a[AW-1:3] ^ 31'h2A5A_5A5A};
    endfunction

    // ---------------- cache store model (environment) ----------------
    typedef struct packed {
        logic [5:0]  off;
        logic [63:0] data;
        logic [21:0] tag;
        logic [5:0]  idx;
    } wr_t;

    logic        sv  [64];
    logic [21:0] stg [64];
    logic [63:0] sd  [64][8];
    wr_t         wr_q[$];
    int          n_en = 0;

    always_comb begin
        bus.st_hit      = 1'b0;
        bus.st_valid    = 1'b0;
        bus.st_data_out = '0;
        if (bus.st_enable && bus.st_comp && !bus.st_write) begin
            bus.st_valid    = sv[bus.st_index];
            bus.st_hit      = sv[bus.st_index] && (stg[bus.st_index] == bus.st_tag);
            bus.st_data_out = sd[bus.st_index][bus.st_offset[5:3]];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) sv[i] <= 1'b0;
        end else if (bus.st_enable) begin
            n_en <= n_en + 1;
            if (bus.st_write && !bus.st_comp) begin
                sd[bus.st_index][bus.st_offset[5:3]] <= bus.st_data_in;
                stg[bus.st_index] <= bus.st_tag;
                sv[bus.st_index]  <= bus.st_valid_in;
                wr_q.push_back('{bus.st_offset, bus.st_data_in, bus.st_tag, bus.st_index});
            end
        end
    end

    // ---------------- reference model ----------------
    bit          mv [64];
    logic [21:0] mt [64];
    int          exp_hit = 0;
    int          exp_mis = 0;

    function automatic bit model_miss(input logic [AW-1:0] a);
        return !(mv[a[11:6]] && mt[a[11:6]] == a[AW-1:12]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        exp_hit = 0;
        exp_mis = 0;
    endtask

    // ---------------- one fetch transaction ----------------
    typedef struct {
        bit          got;
        bit          err;
        logic [63:0] data;
        int          lat;
        int          nreq;
        logic [AW-1:0] maddr;
        int          gaps;
        bit          rdy_bad;
        bit          strobe_bad;
        bit          aborted;
    } fres_t;

    task automatic idle_inputs();
        bus.req_valid     = 1'b0;
        bus.mem_gnt       = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    // junk: drive spurious req_valid/mem_gnt/mem_rsp_valid where they must be ignored
    // abort_beats > 0: return as soon as that many fill beats have been taken
    task automatic fetch(input logic [AW-1:0] a, input int gdly, input int gapmax,
                         input bit junk, input int abort_beats, output fres_t r);
        int cyc, gw, beat, gap;
        bit granted;
        logic [AW-1:0] line;
        r = '{default:0};
        line = {a[AW-1:6], 6'b0};
        @(negedge clk);
        if (bus.req_ready !== 1'b1) r.rdy_bad = 1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1; gw = 0; beat = 0; granted = 0;
        gap = $urandom_range(0, gapmax);
        while (cyc <= 400) begin
            idle_inputs();
            if (abort_beats > 0 && beat == abort_beats) begin
                r.aborted = 1;
                return;
            end
            if (bus.rsp_valid === 1'b1) begin
                r.got  = 1;
                r.lat  = cyc;
                r.err  = bus.rsp_err;
                r.data = bus.rsp_data;
                break;
            end
            if (bus.req_ready !== 1'b0) r.rdy_bad = 1;
            if (junk) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_addr  = AW'($urandom);
            end
            if (bus.mem_req === 1'b1) begin
                r.nreq++;
                r.maddr = bus.mem_addr;
                if (junk) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = {$urandom, $urandom};
                end
                if (gw >= gdly) begin
                    bus.mem_gnt = 1'b1;
                    granted = 1;
                end else begin
                    gw++;
                end
            end else if (granted && beat < 8) begin
                if (gap > 0) begin
                    gap--;
                    r.gaps++;
                end else begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(line | AW'(beat * 8));
                    beat++;
                    gap = $urandom_range(0, gapmax);
                end
            end else if (junk) begin
                bus.mem_gnt       = 1'($urandom_range(0, 1));
                bus.mem_rsp_valid = 1'($urandom_range(0, 1));
                bus.mem_rsp_data  = {$urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        if (r.got) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) r.strobe_bad = 1;
        end
    endtask

    task automatic run_fetch(input string nm, input logic [AW-1:0] a, input int gdly,
                             input int gapmax, input bit junk, input bit exp_err, input bit exp_miss);
        fres_t r;
        int en0;
        bit wr_ok;
        logic [AW-1:0] line;
        line = {a[AW-1:6], 6'b0};
        wr_q.delete();
        en0 = n_en;
        fetch(a, gdly, gapmax, junk, 0, r);
        chk({nm, " rsp_seen"}, 64'(r.got), 64'(1));
        if (!r.got) return;
        chk({nm, " err"}, 64'(r.err), 64'(exp_err));
        chk({nm, " data"}, r.data, exp_err ? 64'(0) : mem_word(a));
        chk({nm, " latency"}, 64'(r.lat), exp_miss ? 64'(12 + gdly + r.gaps) : 64'(2));
        chk({nm, " mem_req_cycles"}, 64'(r.nreq), exp_miss ? 64'(gdly + 1) : 64'(0));
        if (exp_miss) chk({nm, " mem_addr"}, 64'(r.maddr), 64'(line));
        chk({nm, " fill_writes"}, 64'(wr_q.size()), exp_miss ? 64'(8) : 64'(0));
        wr_ok = 1;
        foreach (wr_q[k]) begin
            if (wr_q[k].off != 6'(k * 8) || wr_q[k].data != mem_word(line | AW'(k * 8)) ||
                wr_q[k].tag != a[AW-1:12] || wr_q[k].idx != a[11:6]) wr_ok = 0;
        end
        chk({nm, " fill_order"}, 64'(wr_ok), 64'(1));
        chk({nm, " store_accesses"}, 64'(n_en - en0), exp_err ? 64'(0) : (exp_miss ? 64'(10) : 64'(1)));
        chk({nm, " req_ready_busy"}, 64'(r.rdy_bad), 64'(0));
        chk({nm, " single_strobe"}, 64'(r.strobe_bad), 64'(0));
        if (!exp_err) begin
            if (exp_miss) begin
                mv[a[11:6]] = 1'b1;
                mt[a[11:6]] = a[AW-1:12];
                if (exp_mis < CMAX) exp_mis++;
            end
            if (exp_hit < CMAX) exp_hit++;
        end
        chk({nm, " hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
        chk({nm, " miss_cnt"}, 64'(miss_cnt), 64'(exp_mis));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'(1));
        chk({nm, " rsp"}, 64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
        chk({nm, " rsp_data"}, bus.rsp_data, 64'(0));
        chk({nm, " st_ctl"}, 64'({bus.st_enable, bus.st_comp, bus.st_write, bus.st_valid_in,
                                  bus.st_tag, bus.st_index, bus.st_offset}), 64'(0));
        chk({nm, " st_data_in"}, bus.st_data_in, 64'(0));
        chk({nm, " mem"}, 64'({bus.mem_req, bus.mem_addr}), 64'(0));
        chk({nm, " counters"}, 64'({hit_cnt, miss_cnt}), 64'(0));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string         nm;
        logic [AW-1:0] addr;
        int            gdly;
        int            gapmax;
        bit            err;
        bit            miss;
    } vec_t;

    vec_t tbl[8];

    initial begin
        fres_t r;
        logic [AW-1:0] a;
        bit e;

        tbl[0] = '{"misalign4",  34'h0_0000_1004, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{"coldmiss",   34'h0_0000_1048, 0, 0, 1'b0, 1'b1};
        tbl[2] = '{"warmhit",    34'h0_0000_1078, 0, 0, 1'b0, 1'b0};
        tbl[3] = '{"gntstall",   34'h2_0000_0010, 5, 3, 1'b0, 1'b1};
        tbl[4] = '{"misalign1",  34'h0_0000_1041, 0, 0, 1'b1, 1'b0};
        tbl[5] = '{"hit2",       34'h2_0000_0038, 0, 0, 1'b0, 1'b0};
        tbl[6] = '{"conflict",   34'h0_0000_2040, 2, 1, 1'b0, 1'b1};
        tbl[7] = '{"evicted",    34'h0_0000_1048, 0, 2, 1'b0, 1'b1};

        idle_inputs();
        bus.req_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        foreach (tbl[i])
            run_fetch(tbl[i].nm, tbl[i].addr, tbl[i].gdly, tbl[i].gapmax, 1'b0, tbl[i].err, tbl[i].miss);

        // reset while the fill is three beats in
        a = 34'h0_0000_3088;
        fetch(a, 1, 1, 1'b0, 3, r);
        chk("midfill aborted", 64'(r.aborted), 64'(1));
        rst = 1'b1;
        #1;
        chk_reset_outputs("midfill_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_fetch("refetch", a, 1, 2, 1'b0, 1'b0, 1'b1);

        // randomized traffic over a small footprint so lines conflict
        for (int n = 0; n < 200; n++) begin
            a = {20'(0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'b000};
            if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
            e = (a[2:0] != 3'b000);
            run_fetch("rand", a, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, e, !e && model_miss(a));
        end

        // saturate the miss counter with ping-pong conflicts, then the hit counter
        for (int n = 0; n < CMAX + 4; n++) begin
            a = {22'(n % 2 + 16), 6'd9, 6'd16};
            run_fetch("misssat", a, 0, 0, 1'b0, 1'b0, model_miss(a));
        end
        for (int n = 0; n < CMAX + 4; n++) begin
            a = {22'd5, 6'd12, 6'(8 * (n % 8))};
            run_fetch("hitsat", a, 0, 0, 1'b0, 1'b0, model_miss(a));
        end
        chk("hit_cnt saturated", 64'(hit_cnt), 64'(CMAX));
        chk("miss_cnt saturated", 64'(miss_cnt), 64'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Initiator-side controller for the L1 instruction cache store.
- Accepts fetch requests from the core and drives compare-reads into the store.
- On a miss, requests the 64B line from the lower memory level and fills the store with eight fill-writes (comp=0, write=1, valid_in=1), one per 8B word.
- Then re-issues the compare-read and returns the instruction word to the core.

Parameters:
- TAG_W, 22, tag width; must equal `L1_TAG_WIDTH.
- INDEX_W, 6, index width; must equal `L1_INDEX_WIDTH.
- OFFSET_W, 6, offset width (64B line, eight 8B words).
- DATA_W, 64, instruction word width; must equal `L1_ICACHE_DATA_WIDTH.
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request from core.
- req_addr  in  TAG_W+INDEX_W+OFFSET_W  fetch byte address.
- req_ready  out  1  controller accepts a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  DATA_W  instruction word.
- rsp_err  out  1  misaligned fetch; rsp_data is 0.
- st_enable  out  1  store enable.
- st_tag  out  TAG_W  store tag_in.
- st_index  out  INDEX_W  store index.
- st_offset  out  OFFSET_W  store offset.
- st_data_in  out  DATA_W  store data_in.
- st_comp  out  1  store comp.
- st_write  out  1  store write.
- st_valid_in  out  1  store valid_in.
- st_hit  in  1  store hit.
- st_valid  in  1  store valid.
- st_data_out  in  DATA_W  store data_out.
- mem_req  out  1  line read request to lower level.
- mem_addr  out  TAG_W+INDEX_W+OFFSET_W  line-aligned address; low OFFSET_W bits are 0.
- mem_gnt  in  1  request accepted.
- mem_rsp_valid  in  1  fill word valid; words arrive in order 0..7.
- mem_rsp_data  in  DATA_W  fill word.
- hit_cnt  out  CNT_W  saturating count of hit responses.
- miss_cnt  out  CNT_W  saturating count of line fills started.

Behaviour:
- State machine: IDLE, LOOKUP, MREQ, FILL, ERR.
- Reset values:
  - State = IDLE; word counter = 0; address latch = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - All st_* outputs = 0; mem_req = 0; mem_addr = 0.
  - hit_cnt = 0, miss_cnt = 0.
- IDLE:
  - req_ready = 1; all other control outputs are 0.
  - On req_valid: latch req_addr.
  - If req_addr[2:0] != 0, go to ERR. Otherwise go to LOOKUP.
- ERR: for one cycle, drive rsp_valid = 1, rsp_err = 1, rsp_data = 0; then go to IDLE. The store is not accessed.
- LOOKUP (one cycle):
  - Drive st_enable = 1, st_comp = 1, st_write = 0; tag, index and offset come from the latch.
  - If st_hit & st_valid: register rsp_valid = 1 and rsp_data = st_data_out for the next cycle, increment hit_cnt, go to IDLE.
  - Otherwise: increment miss_cnt, go to MREQ.
- MREQ:
  - Hold mem_req = 1 and mem_addr = {tag, index, 0} until mem_gnt is sampled high.
  - Then clear the word counter and go to FILL.
- FILL:
  - On each mem_rsp_valid, in the same cycle drive st_enable = 1, st_write = 1, st_comp = 0, st_valid_in = 1, st_offset = {counter, 3'b000}, st_data_in = mem_rsp_data; then increment the counter.
  - In cycles without mem_rsp_valid, st_enable and st_write are 0.
  - When word 7 is written, the counter wraps to 0 and the state goes to LOOKUP. The re-lookup is required to hit.
- Latency:
  - Hit: rsp_valid 2 cycles after the accept edge.
  - Miss: 2 cycles + grant wait + eight fill beats + 2 cycles.
- req_ready = 0 in every state except IDLE.
- rsp_valid is a single-cycle strobe; the core must not backpressure.
- mem_rsp_valid outside FILL is ignored. mem_gnt outside MREQ is ignored.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-fill returns the controller to IDLE immediately. The store shares rst, so a partially filled line is discarded by the store's own reset.
- Core-side outputs other than rsp_* are combinational from state plus the latch. rsp_* are registered.

Test Plan:
- Misaligned fetch: addr 0x...0004 -> rsp_err = 1 and rsp_data = 0 two cycles after accept; no st_enable pulse; counters unchanged.
- Cold miss then fill: addr 0x1048 on an empty cache -> mem_req with mem_addr 0x1040; feed words W0..W7 -> eight st_write pulses at offsets 0x00..0x38; response rsp_data = W1; miss_cnt = 1, hit_cnt = 1.
- Warm hit: a second fetch to 0x1078 -> rsp_valid exactly 2 cycles after accept with rsp_data = W7; no mem_req; hit_cnt = 2.
- Grant stall and gapped fill: hold mem_gnt low for 5 cycles, then insert idle cycles between fill beats -> mem_req held high throughout; writes occur only on mem_rsp_valid cycles; the word order is preserved.
- Reset mid-fill after 3 beats: -> state IDLE, req_ready = 1, all outputs at reset values. A refetch of the same address misses again and fills the full line.
- Counter saturation: preload via 2^CNT_W hits -> hit_cnt holds 0xFFFF.
